// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: data, MDU and eret hazards plus exception flush.
// Define MDU_HAZARD_EN to build the multiply/divide busy counter and its stall; otherwise md_busy is tied 0.
module pipe_hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] e_dst,
   input  logic [4:0] m_dst,
   input  logic [1:0] e_tnew,
   input  logic [1:0] m_tnew,
   input  logic       d_is_md,
   input  logic       e_md_start,
   input  logic       e_md_div,
   input  logic       d_is_eret,
   input  logic       e_mtc0_epc,
   input  logic       m_mtc0_epc,
   input  logic       exc_req,
   output logic       stall,
   output logic       flush_e,
   output logic       req,
   output logic       md_busy
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall_eret;

   // A source stalls only when a producer in E or M will not have its result ready in time.
   assign stall_rs = (d_rs != 5'd0) &
                     (((d_rs == e_dst) & (e_tnew > d_tuse_rs)) |
                      ((d_rs == m_dst) & (m_tnew > d_tuse_rs)));
   assign stall_rt = (d_rt != 5'd0) &
                     (((d_rt == e_dst) & (e_tnew > d_tuse_rt)) |
                      ((d_rt == m_dst) & (m_tnew > d_tuse_rt)));

`ifdef MDU_HAZARD_EN
   localparam logic [3:0] MULT_LAT = 4'd5;
   localparam logic [3:0] DIV_LAT  = 4'd10;

   logic [3:0] cnt;

   // Not cleared by an exception: a launched MDU op always runs to completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
      end else if (e_md_start) begin
         cnt <= e_md_div ? DIV_LAT : MULT_LAT;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign md_busy  = (cnt != 4'd0);
   assign stall_md = d_is_md & (md_busy | e_md_start);
`else
   logic unused_md;

   assign unused_md = ^{clk, reset, d_is_md, e_md_start, e_md_div};
   assign md_busy   = 1'b0;
   assign stall_md  = 1'b0;
`endif

   // eret must wait until any in-flight mtc0 to EPC has been written.
   assign stall_eret = d_is_eret & (e_mtc0_epc | m_mtc0_epc);

   assign req     = exc_req;
   assign stall   = (stall_rs | stall_rt | stall_md | stall_eret) & ~req;
   assign flush_e = stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus random traffic
// checked every cycle against a timestamp-based behavioural model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs, d_rt, e_dst, m_dst;
   logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic       d_is_md, e_md_start, e_md_div, d_is_eret;
   logic       e_mtc0_epc, m_mtc0_epc, exc_req;
   logic       stall, flush_e, req, md_busy;

   int vectors    = 0;
   int miscompares = 0;
   bit check_en   = 1'b0;

   // model state: absolute cycle numbers over which the MDU is busy
   int cyc     = 0;
   int busy_lo = 0;
   int busy_hi = -1;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .e_dst(e_dst), .m_dst(m_dst), .e_tnew(e_tnew), .m_tnew(m_tnew),
      .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_div(e_md_div),
      .d_is_eret(d_is_eret), .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc),
      .exc_req(exc_req),
      .stall(stall), .flush_e(flush_e), .req(req), .md_busy(md_busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic bit src_hazard(input logic [4:0] r, input logic [1:0] tuse);
      int t;
      t = tuse;
      if (r == 0) return 1'b0;
      if (r == e_dst && int'(e_tnew) > t) return 1'b1;
      if (r == m_dst && int'(m_tnew) > t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_busy();
`ifdef MDU_HAZARD_EN
      return (cyc >= busy_lo) && (cyc <= busy_hi);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_stall();
      bit s;
      s = src_hazard(d_rs, d_tuse_rs) || src_hazard(d_rt, d_tuse_rt);
`ifdef MDU_HAZARD_EN
      s = s || (d_is_md && (model_busy() || e_md_start));
`endif
      s = s || (d_is_eret && (e_mtc0_epc || m_mtc0_epc));
      return s && !exc_req;
   endfunction

   task automatic cmp(input string name, input logic act, input logic exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // compare process + model update, once per cycle
   always @(negedge clk) begin
      if (check_en) begin
         cmp("model_stall", stall, model_stall());
         cmp("model_flush_e", flush_e, model_stall());
         cmp("model_req", req, exc_req);
         cmp("model_md_busy", md_busy, model_busy());
      end
      if (reset) begin
         busy_lo = 0;
         busy_hi = -1;
      end else if (e_md_start) begin
         busy_lo = cyc + 1;
         busy_hi = cyc + (e_md_div ? 10 : 5);
      end
      cyc = cyc + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
      e_dst = 0; m_dst = 0; e_tnew = 0; m_tnew = 0;
      d_is_md = 0; e_md_start = 0; e_md_div = 0; d_is_eret = 0;
      e_mtc0_epc = 0; m_mtc0_epc = 0; exc_req = 0;
   endtask

   task automatic rand_inputs();
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      e_dst = 5'($urandom_range(0, 3)); m_dst = 5'($urandom_range(0, 3));
      d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
      e_tnew = 2'($urandom_range(0, 3)); m_tnew = 2'($urandom_range(0, 3));
      d_is_md = ($urandom_range(0, 2) == 0);
      e_md_start = ($urandom_range(0, 9) == 0);
      e_md_div = $urandom_range(0, 1);
      d_is_eret = ($urandom_range(0, 3) == 0);
      e_mtc0_epc = ($urandom_range(0, 3) == 0);
      m_mtc0_epc = ($urandom_range(0, 3) == 0);
      exc_req = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 59) == 0);
   endtask

   localparam bit MD_ON =
`ifdef MDU_HAZARD_EN
      1'b1;
`else
      1'b0;
`endif

   initial begin
      idle();
      reset = 1'b1;
      tick(); tick();
      check_en = 1'b1;
      tick();
      reset = 1'b0;

      // reset state with idle inputs
      settle();
      cmp("reset_stall", stall, 1'b0);
      cmp("reset_req", req, 1'b0);
      cmp("reset_md_busy", md_busy, 1'b0);

      // load-use
      tick();
      e_dst = 8; e_tnew = 2; d_rs = 8; d_tuse_rs = 0;
      settle();
      cmp("loaduse_stall", stall, 1'b1);
      cmp("loaduse_flush_e", flush_e, 1'b1);
      tick();
      e_dst = 0;
      settle();
      cmp("loaduse_clear", stall, 1'b0);

      // register $0 never stalls
      tick();
      idle();
      e_dst = 0; d_rt = 0; e_tnew = 2; d_tuse_rt = 0;
      settle();
      cmp("zero_reg", stall, 1'b0);

      // divide sequencing with d_is_md held
      tick();
      idle();
      e_md_start = 1; e_md_div = 1; d_is_md = 1;
      settle();
      cmp("div_stall_0", stall, MD_ON);
      cmp("div_busy_0", md_busy, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         tick();
         e_md_start = 0;
         settle();
         cmp("div_stall", stall, MD_ON && (k <= 10));
         cmp("div_busy", md_busy, MD_ON && (k <= 10));
      end

      // exception priority over load-use while a mult counts down
      tick();
      idle();
      e_md_start = 1;
      settle();
      for (int k = 1; k <= 6; k++) begin
         tick();
         idle();
         e_dst = 8; e_tnew = 2; d_rs = 8; d_tuse_rs = 0; exc_req = 1;
         settle();
         cmp("exc_req", req, 1'b1);
         cmp("exc_stall", stall, 1'b0);
         cmp("exc_flush_e", flush_e, 1'b0);
         cmp("exc_busy", md_busy, MD_ON && (k <= 5));
      end

      // eret waits for mtc0 EPC
      tick();
      idle();
      d_is_eret = 1; m_mtc0_epc = 1;
      settle();
      cmp("eret_stall", stall, 1'b1);
      tick();
      m_mtc0_epc = 0;
      settle();
      cmp("eret_clear", stall, 1'b0);

      // reset mid-mult
      tick();
      idle();
      e_md_start = 1;
      settle();
      tick();
      e_md_start = 0;
      settle();
      cmp("rst_mult_busy1", md_busy, MD_ON);
      tick();
      reset = 1;
      settle();
      cmp("rst_mult_busy2", md_busy, MD_ON);
      tick();
      reset = 0;
      settle();
      cmp("rst_mult_busy3", md_busy, 1'b0);

      // random traffic, checked by the model every cycle
      for (int i = 0; i < 600; i++) begin
         tick();
         rand_inputs();
      end
      tick();
      idle();
      reset = 0;
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
